// File: rtl/qstate_prob_reader_pkg.sv
// qstate_prob_reader_pkg: fixed-point widths, unit probability and readout FSM encodings
package qstate_prob_reader_pkg;
  localparam int TOTAL_WIDTH = 8;
  localparam int FRAC_BITS = 4;
  localparam int PROB_ONE = 1 << (2 * FRAC_BITS);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
endpackage

// File: rtl/qstate_prob_reader_mag_sq.sv
// cplx_mag_sq: full-precision |a|^2 of a signed complex amplitude, reusable by measurement blocks
module cplx_mag_sq #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] re,
  input  logic signed [W-1:0] im,
  output logic [2*W:0]        mag_sq
);
  logic signed [2*W-1:0] rr, ii;
  // Squares are never negative, so a zero-extended 2W+1-bit sum cannot overflow even for -2^(W-1).
  assign rr = (2*W)'(re) * (2*W)'(re);
  assign ii = (2*W)'(im) * (2*W)'(im);
  assign mag_sq = {1'b0, rr} + {1'b0, ii};
endmodule

// File: rtl/qstate_prob_reader.sv
// qstate_prob_reader: reads every amplitude, streams |a|^2 with valid/ready and checks normalisation
module qstate_prob_reader import qstate_prob_reader_pkg::*; #(
  parameter int N_QUBITS = 2,
  parameter int W = TOTAL_WIDTH,
  parameter int FRAC = FRAC_BITS,
  parameter int NORM_TOL = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      rd_en,
  output logic [N_QUBITS-1:0]       rd_addr,
  input  logic signed [W-1:0]       rd_data_r,
  input  logic signed [W-1:0]       rd_data_i,
  output logic [2*W:0]              prob_data,
  output logic [N_QUBITS-1:0]       prob_idx,
  output logic                      prob_last,
  output logic                      prob_valid,
  input  logic                      prob_ready,
  output logic [2*W+N_QUBITS:0]     norm_sum,
  output logic                      norm_ok,
  output logic                      done
);
  localparam int PW = 2 * W + 1;
  localparam int SW = PW + N_QUBITS;
  localparam logic [SW-1:0] ONE = SW'(1) << (2 * FRAC);
  localparam logic [SW-1:0] LO = ONE - SW'(NORM_TOL);
  localparam logic [SW-1:0] HI = ONE + SW'(NORM_TOL);
  logic [2:0] state_q, state_d;
  logic [N_QUBITS-1:0] idx_q, idx_d, pidx_q, pidx_d;
  logic [PW-1:0] prob_q, prob_d, mag;
  logic [SW-1:0] sum_q, sum_d;
  logic plast_q, plast_d, ok_q, ok_d;
  cplx_mag_sq #(.W(W)) u_mag (.re(rd_data_r), .im(rd_data_i), .mag_sq(mag));
  // Readout sequencing: one fetch, one capture and one output beat per basis state.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    pidx_d = pidx_q;
    prob_d = prob_q;
    plast_d = plast_q;
    sum_d = sum_q;
    ok_d = ok_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        idx_d = '0;
        sum_d = '0;
        ok_d = 1'b0;
      end
      S_FETCH: state_d = S_CALC;
      S_CALC: begin
        prob_d = mag;
        pidx_d = idx_q;
        plast_d = idx_q == {N_QUBITS{1'b1}};
        sum_d = sum_q + SW'(mag);
        state_d = S_SEND;
      end
      S_SEND: if (prob_ready) begin
        state_d = plast_q ? S_DONE : S_FETCH;
        idx_d = plast_q ? idx_q : idx_q + N_QUBITS'(1);
        ok_d = plast_q ? (sum_q >= LO && sum_q <= HI) : ok_q;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // State registers; reset aborts any readout without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      pidx_q <= '0;
      prob_q <= '0;
      plast_q <= 1'b0;
      sum_q <= '0;
      ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      pidx_q <= pidx_d;
      prob_q <= prob_d;
      plast_q <= plast_d;
      sum_q <= sum_d;
      ok_q <= ok_d;
    end
  end
  assign busy = state_q != S_IDLE;
  assign rd_en = state_q == S_FETCH;
  assign rd_addr = idx_q;
  assign prob_valid = state_q == S_SEND;
  assign done = state_q == S_DONE;
  assign prob_data = prob_q;
  assign prob_idx = pidx_q;
  assign prob_last = plast_q;
  assign norm_sum = sum_q;
  assign norm_ok = ok_q;
endmodule

// File: tb/tb_qstate_prob_reader.sv
// tb_qstate_prob_reader: directed and random readouts checked against an arithmetic probability model
module tb_qstate_prob_reader;
  localparam int N = 1, W = 8, D = 2, PW = 2 * W + 1, SW = PW + N;
  logic clk = 1'b0;
  logic rst, start, busy, rd_en, prob_last, prob_valid, prob_ready, norm_ok, done;
  logic [N-1:0] rd_addr, prob_idx;
  logic signed [W-1:0] rd_data_r, rd_data_i;
  logic [PW-1:0] prob_data;
  logic [SW-1:0] norm_sum;
  int mem_r[D], mem_i[D];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  // Synchronous-read state memory
  always @(posedge clk) if (rd_en) begin
    rd_data_r <= W'(mem_r[rd_addr]);
    rd_data_i <= W'(mem_i[rd_addr]);
  end
  qstate_prob_reader #(.N_QUBITS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data_r(rd_data_r), .rd_data_i(rd_data_i), .prob_data(prob_data), .prob_idx(prob_idx),
    .prob_last(prob_last), .prob_valid(prob_valid), .prob_ready(prob_ready),
    .norm_sum(norm_sum), .norm_ok(norm_ok), .done(done)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic load(input int r0, input int i0, input int r1, input int i1);
    mem_r[0] = r0; mem_i[0] = i0; mem_r[1] = r1; mem_i[1] = i1;
  endtask
  task automatic readout(input int stall);
    int sum, cyc, p;
    sum = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < D; k++) begin
      p = mem_r[k] * mem_r[k] + mem_i[k] * mem_i[k];
      cyc = 0;
      while (prob_valid !== 1'b1 && cyc < 20) begin
        step();
        cyc++;
      end
      chk("latency", 64'(cyc), 64'd2);
      chk("prob_data", 64'(prob_data), 64'(p));
      chk("prob_idx", 64'(prob_idx), 64'(k));
      chk("prob_last", 64'(prob_last), 64'(k == D - 1));
      chk("send_rd_en", 64'(rd_en), 64'd0);
      sum += p;
      if (k == 0 && stall > 0) begin
        prob_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          step();
          chk("stall_valid", 64'(prob_valid), 64'd1);
          chk("stall_data", 64'(prob_data), 64'(p));
          chk("stall_idx", 64'(prob_idx), 64'(k));
          chk("stall_rd_en", 64'(rd_en), 64'd0);
        end
        prob_ready = 1'b1;
      end
      step();
    end
    chk("done", 64'(done), 64'd1);
    chk("norm_sum", 64'(norm_sum), 64'(sum));
    chk("norm_ok", 64'(norm_ok), 64'(sum >= 256 - 16 && sum <= 256 + 16));
    step();
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("hold_sum", 64'(norm_sum), 64'(sum));
    chk("hold_ok", 64'(norm_ok), 64'(sum >= 256 - 16 && sum <= 256 + 16));
  endtask
  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    prob_ready = 1'b1;
    load(0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_valid", 64'(prob_valid), 64'd0);
    chk("rst_sum", 64'(norm_sum), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    load(10, 0, 0, 13);
    readout(0);
    load(16, 0, 0, 0);
    readout(0);
    load(16, 0, 16, 0);
    readout(0);
    load(-128, -128, 0, 0);
    readout(0);
    load(7, -9, -12, 5);
    readout(5);
    load(3, 4, -5, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (prob_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    step();
    cyc = 0;
    while (prob_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("abort_beat1_idx", 64'(prob_idx), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rd_en", 64'(rd_en), 64'd0);
    chk("abort_rd_addr", 64'(rd_addr), 64'd0);
    chk("abort_valid", 64'(prob_valid), 64'd0);
    chk("abort_data", 64'(prob_data), 64'd0);
    chk("abort_idx", 64'(prob_idx), 64'd0);
    chk("abort_last", 64'(prob_last), 64'd0);
    chk("abort_sum", 64'(norm_sum), 64'd0);
    chk("abort_ok", 64'(norm_ok), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    step();
    chk("abort_no_done", 64'(done), 64'd0);
    readout(0);
    for (int t = 0; t < 8; t++) begin
      load(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      readout(int'($urandom_range(0, 4)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
